// File: rtl/arb_req_pkg.sv
// rtl/arb_req_pkg.sv - shared types and helpers for the arbiter request master
package arb_req_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    // OR-reduction encoder; only meaningful for one-hot input
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_pend_cnt.sv
// rtl/arb_pend_cnt.sv - saturating pending-transaction counter for one port
module arb_pend_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    // A simultaneous inc and dec cancel, so a push at saturation is not lost then
    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count == MAX_CNT) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/arb_req_master.sv
// rtl/arb_req_master.sv - request generator and grant consumer for a round-robin arbiter
module arb_req_master
    import arb_req_pkg::*;
#(
    parameter int NUM_PORTS = 20,
    parameter int CNT_W     = 4,
    parameter int HOLD_CYC  = 2,
    localparam int IDX_W    = idx_width(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] push_i,
    input  logic [NUM_PORTS-1:0] gnt_i,
    output logic [NUM_PORTS-1:0] req_o,
    output logic                 busy_o,
    output logic                 served_vld_o,
    output logic [IDX_W-1:0]     served_idx_o,
    output logic [NUM_PORTS-1:0] overflow_o,
    output logic                 gnt_err_o
);

    localparam logic [3:0] HOLD_LOAD = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           hold_cnt;
    logic [3:0]           hold_nxt;
    logic [NUM_PORTS-1:0] pend_nz;
    logic [NUM_PORTS-1:0] dec;
    logic [31:0]          gnt_w;
    logic [4:0]           gnt_idx;
    logic                 accept;

    assign gnt_w   = 32'(gnt_i);
    assign gnt_idx = onehot_to_idx(gnt_w);
    assign req_o   = (state == IDLE) ? pend_nz : '0;
    assign busy_o  = (state == HOLD);
    // req_o is already zero outside IDLE, so this rejects grants during HOLD too
    assign accept  = is_onehot(gnt_w) && ((gnt_i & req_o) != '0);
    assign dec     = accept ? gnt_i : '0;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [CNT_W-1:0] count;

        arb_pend_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (push_i[p]),
            .dec     (dec[p]),
            .count   (count),
            .overflow(overflow_o[p])
        );

        assign pend_nz[p] = (count != '0);
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (accept && (HOLD_CYC > 0)) begin
                    state_nxt = HOLD;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    hold_nxt = hold_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            served_vld_o <= 1'b0;
            served_idx_o <= '0;
            gnt_err_o    <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_nxt;
            served_vld_o <= accept;
            served_idx_o <= accept ? gnt_idx[IDX_W-1:0] : '0;
            if ((gnt_i != '0) && !accept) begin
                gnt_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arb_req_master.sv
// tb/tb_arb_req_master.sv - scoreboard bench for arb_req_master (HOLD 2 and HOLD 0 instances)
module tb_arb_req_master;

    localparam int NP     = 20;
    localparam int CW     = 4;
    localparam int IW     = $clog2(NP);
    localparam int MAXP   = (1 << CW) - 1;
    localparam int HOLD_A = 2;
    localparam int HOLD_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NP-1:0] push_a, gnt_a, push_b, gnt_b;
    logic [NP-1:0] req_a, req_b, ovf_a, ovf_b;
    logic          busy_a, busy_b, sv_a, sv_b, err_a, err_b;
    logic [IW-1:0] idx_a, idx_b;

    arb_req_master #(.NUM_PORTS(NP), .CNT_W(CW), .HOLD_CYC(HOLD_A)) dut_a (
        .clk(clk), .rst(rst), .push_i(push_a), .gnt_i(gnt_a), .req_o(req_a),
        .busy_o(busy_a), .served_vld_o(sv_a), .served_idx_o(idx_a),
        .overflow_o(ovf_a), .gnt_err_o(err_a)
    );

    arb_req_master #(.NUM_PORTS(NP), .CNT_W(CW), .HOLD_CYC(HOLD_B)) dut_b (
        .clk(clk), .rst(rst), .push_i(push_b), .gnt_i(gnt_b), .req_o(req_b),
        .busy_o(busy_b), .served_vld_o(sv_b), .served_idx_o(idx_b),
        .overflow_o(ovf_b), .gnt_err_o(err_b)
    );

    // Reference model: integer pending counts and remaining busy cycles per instance
    int            pend [2][NP];
    int            hold_left [2];
    int            hold_cfg [2];
    bit            m_err [2];
    logic [NP-1:0] m_ovf [2];
    int            exp_q0 [$];
    int            exp_q1 [$];
    int            served_cnt [2];
    int            pushes_acc [2];
    int            rr_ptr [2];
    int            passed;
    int            total;
    bit            mon_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NP-1:0] model_req(input int d);
        logic [NP-1:0] r;
        for (int p = 0; p < NP; p++) r[p] = (pend[d][p] != 0) && (hold_left[d] == 0);
        return r;
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic int q_pop(input int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            hold_left[d] = 0;
            m_err[d]     = 1'b0;
            m_ovf[d]     = '0;
            for (int p = 0; p < NP; p++) pend[d][p] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Applies one clock edge of the specified rules to instance d
    task automatic model_step(input int d, input logic [NP-1:0] push, input logic [NP-1:0] gnt);
        logic [NP-1:0] r;
        int g;
        r = model_req(d);
        g = -1;
        if ($countones(gnt) == 1)
            for (int p = 0; p < NP; p++) if (gnt[p]) g = p;
        if (g >= 0 && !r[g]) g = -1;
        if (gnt != '0 && g < 0) m_err[d] = 1'b1;
        if (hold_left[d] > 0) hold_left[d]--;
        if (g >= 0) begin
            pend[d][g]--;
            hold_left[d] = hold_cfg[d];
            if (d == 0) exp_q0.push_back(g);
            else exp_q1.push_back(g);
        end
        for (int p = 0; p < NP; p++) begin
            if (push[p]) begin
                if (pend[d][p] < MAXP) begin
                    pend[d][p]++;
                    pushes_acc[d]++;
                end else begin
                    m_ovf[d][p] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [NP-1:0] rr_pick(input int d, input logic [NP-1:0] r);
        logic [NP-1:0] one;
        one = 1;
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (rr_ptr[d] + k) % NP;
            if (r[p]) begin
                rr_ptr[d] = p;
                return one << p;
            end
        end
        return '0;
    endfunction

    task automatic step(input logic [NP-1:0] pa, input logic [NP-1:0] ga,
                        input logic [NP-1:0] pb, input logic [NP-1:0] gb);
        push_a = pa; gnt_a = ga; push_b = pb; gnt_b = gb;
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            model_step(0, pa, ga);
            model_step(1, pb, gb);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0);
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        step('0, '0, '0, '0);
        rst = 1'b1;
    endtask

    task automatic mon(input int d, input logic [NP-1:0] req, input logic busy, input logic sv,
                       input logic [IW-1:0] idx, input logic [NP-1:0] ovf, input logic err);
        bit want;
        int exp_idx;
        check($sformatf("req_o[%0d]", d), 64'(req), 64'(model_req(d)));
        check($sformatf("busy_o[%0d]", d), 64'(busy), 64'(hold_left[d] > 0));
        check($sformatf("gnt_err_o[%0d]", d), 64'(err), 64'(m_err[d]));
        check($sformatf("overflow_o[%0d]", d), 64'(ovf), 64'(m_ovf[d]));
        want = (q_size(d) > 0);
        check($sformatf("served_vld_o[%0d]", d), 64'(sv), 64'(want));
        if (want) begin
            exp_idx = q_pop(d);
            if (sv) check($sformatf("served_idx_o[%0d]", d), 64'(idx), 64'(exp_idx));
        end else begin
            check($sformatf("served_idx_zero[%0d]", d), 64'(idx), 64'd0);
        end
        if (sv) served_cnt[d]++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon(0, req_a, busy_a, sv_a, idx_a, ovf_a, err_a);
                mon(1, req_b, busy_b, sv_b, idx_b, ovf_b, err_b);
            end
        end
    end

    initial begin
        logic [NP-1:0] r;
        logic [NP-1:0] one;
        int sum;
        one = 1;
        passed = 0; total = 0; mon_en = 1'b0;
        hold_cfg[0] = HOLD_A; hold_cfg[1] = HOLD_B;
        rr_ptr[0] = NP - 1; rr_ptr[1] = NP - 1;
        served_cnt[0] = 0; served_cnt[1] = 0;
        pushes_acc[0] = 0; pushes_acc[1] = 0;
        rst = 1'b0;
        model_reset();

        // Reset dominates all-ones push and grant
        step('1, '1, '1, '1);
        mon_en = 1'b1;
        step('1, '1, '1, '1);
        rst = 1'b1;
        idle(3);

        // Port 3: two pushes, one grant, HOLD window of 2
        step(one << 3, '0, '0, '0);
        step(one << 3, '0, '0, '0);
        step('0, one << 3, '0, '0);
        idle(4);

        // Port 19 saturation, then push and grant together at max
        for (int i = 0; i < 16; i++) step(one << 19, '0, '0, '0);
        step(one << 19, one << 19, '0, '0);
        for (int k = 0; k < 60; k++) begin
            r = model_req(0);
            step('0, r & (one << 19), '0, '0);
        end
        idle(2);

        // Illegal: two bits granted
        rst_pulse();
        step(NP'(3), '0, '0, '0);
        step('0, NP'(3), '0, '0);
        idle(2);
        step('0, one << 0, '0, '0);
        idle(3);
        step('0, one << 1, '0, '0);
        idle(3);

        // Illegal: grant to a port with nothing pending
        rst_pulse();
        step(NP'(3), '0, '0, '0);
        step('0, one << 5, '0, '0);
        idle(2);

        // Illegal: grant during HOLD
        rst_pulse();
        step(one << 2, '0, '0, '0);
        step(one << 2, '0, '0, '0);
        step('0, one << 2, '0, '0);
        step('0, one << 2, '0, '0);
        idle(2);
        step('0, one << 2, '0, '0);
        idle(3);

        // HOLD_CYC = 0 instance: back-to-back accepts
        rst_pulse();
        step('0, '0, NP'(3), '0);
        step('0, '0, '0, one << 0);
        step('0, '0, '0, one << 1);
        idle(2);

        // Random traffic against a round-robin arbiter model
        rst_pulse();
        served_cnt[0] = 0; served_cnt[1] = 0;
        pushes_acc[0] = 0; pushes_acc[1] = 0;
        for (int c = 0; c < 200; c++) begin
            logic [NP-1:0] pa, pb, ga, gb;
            pa = NP'($urandom & $urandom & $urandom);
            pb = NP'($urandom & $urandom & $urandom);
            ga = ($urandom_range(3) != 0) ? rr_pick(0, model_req(0)) : '0;
            gb = ($urandom_range(3) != 0) ? rr_pick(1, model_req(1)) : '0;
            step(pa, ga, pb, gb);
        end
        idle(3);
        for (int d = 0; d < 2; d++) begin
            sum = 0;
            for (int p = 0; p < NP; p++) sum += pend[d][p];
            check($sformatf("served_total[%0d]", d), 64'(served_cnt[d]), 64'(pushes_acc[d] - sum));
        end
        check("gnt_err_random_a", 64'(err_a), 64'd0);
        check("gnt_err_random_b", 64'(err_b), 64'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arb_req_master.md
Name: arb_req_master

Overview:
- Requester-side companion to the team's NUM_PORTS round-robin arbiter: it generates the arbiter's request vector and consumes its one-hot grant vector.
- Each port queues pending transactions in a saturating counter and drives its request bit high while work is pending.
- On a legal grant it retires one transaction, reports the served port index, and occupies the shared resource for a fixed hold window.
- Sits between the per-port traffic sources and the arbiter: req_o feeds the arbiter's req_i, and the arbiter's gnt_o feeds gnt_i.

Parameters:
- NUM_PORTS, 20, number of requesting ports (2..32).
- CNT_W, 4, width of each per-port pending counter (max pending = 2**CNT_W-1).
- HOLD_CYC, 2, cycles busy_o stays high after an accepted grant (0..15; 0 = back-to-back accepts allowed).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low: state clears on a posedge clk where rst==0.
- push_i  input  NUM_PORTS  per-port pulse; enqueues one transaction per cycle per high bit.
- gnt_i  input  NUM_PORTS  grant vector from the arbiter; expected one-hot or zero.
- req_o  output  NUM_PORTS  request vector to the arbiter.
- busy_o  output  1  high during the HOLD window.
- served_vld_o  output  1  one-cycle pulse, high the cycle after an accepted grant.
- served_idx_o  output  IDX_W  index of the served port (IDX_W = clog2(NUM_PORTS)); valid when served_vld_o is high, else 0.
- overflow_o  output  NUM_PORTS  sticky per-port bit: a push was dropped at saturation.
- gnt_err_o  output  1  sticky bit: an illegal grant was observed.

Behaviour:
- Reset (rst==0 at posedge): all pending counters = 0, FSM = IDLE, hold counter = 0, and every output = 0. Reset overrides any simultaneous push or grant. Reset mid-HOLD aborts the window; busy_o is 0 the next cycle.
- req_o[p] = (pending[p] != 0) && (state == IDLE). This is combinational from registers only: no combinational path from gnt_i or push_i.
- FSM IDLE:
  - Accept condition: gnt_i is exactly one-hot, bit g is set, and req_o[g] == 1 in the same cycle.
  - On accept at edge N: pending[g] decrements; served_vld_o = 1 and served_idx_o = g during cycle N+1.
  - If HOLD_CYC > 0, go to HOLD with hold counter = HOLD_CYC-1; otherwise stay in IDLE.
  - gnt_i == 0: no action.
- FSM HOLD:
  - busy_o = 1 and req_o = 0.
  - Hold counter decrements each cycle; return to IDLE on the edge where it is 0. busy_o is therefore high for exactly HOLD_CYC cycles, starting at cycle N+1.
- Illegal grant (ignored; sets gnt_err_o, which stays set until reset):
  - gnt_i has more than one bit set;
  - the granted bit has req_o low;
  - gnt_i is nonzero during HOLD.
- Push arithmetic:
  - push_i[p] increments pending[p].
  - At max value the push is dropped and overflow_o[p] is set.
  - Push and accept on the same port in the same cycle: net unchanged, no overflow even at max.
  - Push on other ports proceeds independently in any state.
- Counter widths: the decrement never underflows, because an accept requires pending != 0. served_idx_o is zero-extended.

Decomposition:
- Package arb_req_pkg:
  - state enum {IDLE, HOLD};
  - IDX_W derivation function (clog2);
  - onehot check function (v != 0 && (v & (v-1)) == 0);
  - binary encoder function from one-hot to index.
- Sub-module arb_pend_cnt: one saturating up/down counter with overflow flag, instantiated NUM_PORTS times in a generate loop. The FSM, hold counter and error logic stay in the top module.

Test Plan:
- Reset with push_i = all ones held high -> after release, all counters stay 0, req_o = 0, and busy_o, served_vld_o, overflow_o and gnt_err_o are all 0.
- Push port 3 twice, grant gnt_i = 1<<3 in IDLE, HOLD_CYC = 2:
  - next cycle served_vld_o = 1 and served_idx_o = 3;
  - busy_o is high for 2 cycles and req_o = 0 during them;
  - then req_o[3] = 1 with pending = 1.
- Push port 19 sixteen times with CNT_W = 4 -> pending = 15 and overflow_o[19] = 1. Then push and grant port 19 in the same cycle -> pending stays 15 and served_idx_o = 19.
- Illegal grants, each followed by a check that no pending counter changed and no served pulse occurred:
  - gnt_i = 0x00003 with both ports pending -> gnt_err_o = 1;
  - gnt_i = 1<<5 with pending[5] = 0 -> gnt_err_o = 1;
  - a grant during HOLD -> gnt_err_o = 1.
- HOLD_CYC = 0, ports 0 and 1 pending, grants 1<<0 then 1<<1 on consecutive cycles -> served_vld_o pulses on two consecutive cycles with idx 0 then 1, and busy_o stays 0.
- Random pushes on 20 ports against the arbiter model for 200 cycles -> total served equals total accepted pushes minus final pending, and gnt_err_o stays 0.
